// File: rtl/mkds_pkg.sv
// Shared types and constants for the MKDS command deserializer.
// Build option: define MKDS_DESER_PARITY_EN to append an odd-parity bit
// to every frame (17-bit frames instead of 16).
package mkds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_EMIT,
    ST_WAIT_END
  } state_t;

  localparam int FRAME_BITS_PAR   = 17;
  localparam int FRAME_BITS_NOPAR = 16;
  localparam int TIMEOUT_DEFAULT  = 255;
  localparam int DATA_BITS        = 16;

`ifdef MKDS_DESER_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  // Odd parity holds when the XOR over data and parity bit is 1.
  function automatic logic odd_parity_ok(input logic [FRAME_BITS_PAR-1:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/mkds_bit_timer.sv
// Counts consecutive enabled cycles; flags the cycle that reaches LIMIT.
// The count saturates so it can never wrap back into a false "fresh" state.
module mkds_bit_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;

  // Count idle cycles, restarting whenever the owner clears the timer.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CW'(LIMIT))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The LIMIT-th consecutive enabled cycle is the one that expires.
  assign expired = enable && !clear && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mkds_cmd_deserializer.sv
// Serial command deserializer: collects an MSB-first frame gated by FRAME,
// one bit per SVALID strobe, and presents the 16-bit word on data_out with
// a one-cycle CS strobe two cycles after the last bit is accepted.
// Build option: MKDS_DESER_PARITY_EN adds a trailing odd-parity bit.
module mkds_cmd_deserializer
  import mkds_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SDI,
  input  logic        SVALID,
  input  logic        FRAME,
  output logic [15:0] data_out,
  output logic        CS,
  output logic        err_frame,
  output logic        err_parity,
  output logic        busy
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t                  state_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0]   shift_next;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [DATA_BITS-1:0]    data_reg;
  logic                    cs_reg;
  logic                    err_frame_reg;
  logic                    timer_enable;
  logic                    timer_clear;
  logic                    timer_expired;
  logic [DATA_BITS-1:0]    word_next;

  assign shift_next = {shift_reg[FRAME_BITS-2:0], SDI};
  // Data occupies the first 16 bits received; a parity bit, if any, is last.
  assign word_next  = shift_reg[FRAME_BITS-1 -: DATA_BITS];

  // The gap timer only runs inside a frame while no strobe arrives.
  assign timer_enable = (state_reg == ST_SHIFT) && !SVALID;
  assign timer_clear  = !timer_enable;

  mkds_bit_timer #(
    .LIMIT(TIMEOUT)
  ) u_bit_timer (
    .clk    (CLK),
    .srst   (RST),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

`ifdef MKDS_DESER_PARITY_EN
  logic err_parity_reg;
  logic frame_good;

  assign frame_good = odd_parity_ok(shift_reg);
`endif

  // Frame sequencing, shift register, bit counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      data_reg      <= '0;
      cs_reg        <= 1'b0;
      err_frame_reg <= 1'b0;
`ifdef MKDS_DESER_PARITY_EN
      err_parity_reg <= 1'b0;
`endif
    end else begin
      cs_reg        <= 1'b0;
      err_frame_reg <= 1'b0;
`ifdef MKDS_DESER_PARITY_EN
      err_parity_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          // Anything left from an aborted frame is dropped here.
          shift_reg   <= '0;
          bit_cnt_reg <= '0;
          if (FRAME) begin
            state_reg <= ST_SHIFT;
            if (SVALID) begin
              shift_reg   <= {{(FRAME_BITS-1){1'b0}}, SDI};
              bit_cnt_reg <= CNT_W'(1);
            end
          end
        end

        ST_SHIFT: begin
          if (SVALID) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            // The final bit completes the frame even if FRAME falls with it.
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= ST_CHECK;
            end else if (!FRAME) begin
              err_frame_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end
          end else if (!FRAME) begin
            err_frame_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end else if (timer_expired) begin
            err_frame_reg <= 1'b1;
            state_reg     <= ST_WAIT_END;
          end
        end

        ST_CHECK: begin
`ifdef MKDS_DESER_PARITY_EN
          if (frame_good) begin
            data_reg  <= word_next;
            cs_reg    <= 1'b1;
            state_reg <= ST_EMIT;
          end else begin
            err_parity_reg <= 1'b1;
            state_reg      <= ST_WAIT_END;
          end
`else
          data_reg  <= word_next;
          cs_reg    <= 1'b1;
          state_reg <= ST_EMIT;
`endif
        end

        ST_EMIT: begin
          state_reg <= ST_WAIT_END;
        end

        ST_WAIT_END: begin
          if (!FRAME) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_reg;
  assign CS        = cs_reg;
  assign err_frame = err_frame_reg;
  assign busy      = (state_reg != ST_IDLE);

`ifdef MKDS_DESER_PARITY_EN
  assign err_parity = err_parity_reg;
`else
  assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_mkds_cmd_deserializer.sv
// Self-checking bench for mkds_cmd_deserializer (runs with TIMEOUT=8).
// Honours MKDS_DESER_PARITY_EN to match the build of the design.
module tb_mkds_cmd_deserializer;

`ifdef MKDS_DESER_PARITY_EN
  localparam int FB  = 17;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 16;
  localparam bit PAR = 1'b0;
`endif
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SDI = 1'b0;
  logic        SVALID = 1'b0;
  logic        FRAME = 1'b0;
  logic [15:0] data_out;
  logic        CS;
  logic        err_frame;
  logic        err_parity;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mkds_cmd_deserializer #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SDI       (SDI),
    .SVALID    (SVALID),
    .FRAME     (FRAME),
    .data_out  (data_out),
    .CS        (CS),
    .err_frame (err_frame),
    .err_parity(err_parity),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural reference ----------------
  // mode: 0 = waiting for a frame, 1 = collecting bits, 2 = ignoring until FRAME low
  int          m_mode = 0;
  bit          m_bits[$];
  int          m_gap = 0;
  int          m_blind = 0;   // cycles during which the word is being judged/emitted
  bit          m_pending = 1'b0;
  bit          m_good = 1'b0;
  logic [15:0] m_word = 16'h0;
  logic [15:0] exp_data = 16'h0;
  bit          exp_cs = 1'b0;
  bit          exp_ef = 1'b0;
  bit          exp_ep = 1'b0;

  function void word_complete();
    bit x;
    m_word = 16'h0;
    for (int i = 0; i < 16; i++) m_word = {m_word[14:0], m_bits[i]};
    x = 1'b0;
    foreach (m_bits[i]) x = x ^ m_bits[i];
    m_good    = PAR ? x : 1'b1;
    m_blind   = m_good ? 2 : 1;
    m_pending = 1'b1;
  endfunction

  function void model_step();
    exp_cs = 1'b0;
    exp_ef = 1'b0;
    exp_ep = 1'b0;
    if (RST) begin
      m_mode = 0;
      m_bits.delete();
      m_gap = 0;
      m_blind = 0;
      m_pending = 1'b0;
      exp_data = 16'h0;
      return;
    end
    if (m_blind > 0) begin
      if (m_pending) begin
        m_pending = 1'b0;
        if (m_good) begin
          exp_cs   = 1'b1;
          exp_data = m_word;
        end else begin
          exp_ep = 1'b1;
        end
      end
      m_blind--;
      if (m_blind == 0) m_mode = 2;
      return;
    end
    case (m_mode)
      0: begin
        if (FRAME) begin
          m_mode = 1;
          m_bits.delete();
          m_gap = 0;
          if (SVALID) m_bits.push_back(bit'(SDI));
        end
      end
      1: begin
        if (SVALID) begin
          m_bits.push_back(bit'(SDI));
          m_gap = 0;
          if (m_bits.size() == FB) word_complete();
          else if (!FRAME) begin
            exp_ef = 1'b1;
            m_mode = 0;
          end
        end else if (!FRAME) begin
          exp_ef = 1'b1;
          m_mode = 0;
        end else begin
          m_gap++;
          if (m_gap == TO) begin
            exp_ef = 1'b1;
            m_mode = 2;
          end
        end
      end
      default: begin
        if (!FRAME) m_mode = 0;
      end
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_bit(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic check_word(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%04h expected=%04h", nm, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    check_word("data_out", data_out, exp_data);
    check_bit("CS", CS, exp_cs);
    check_bit("err_frame", err_frame, exp_ef);
    check_bit("err_parity", err_parity, exp_ep);
    check_bit("busy", busy, (m_mode != 0) || (m_blind > 0));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare mid-cycle.
  task automatic cycle(input logic f, input logic v, input logic d, input logic r);
    FRAME  = f;
    SVALID = v;
    SDI    = d;
    RST    = r;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [16:0] mkframe(input logic [15:0] w, input bit bad);
    logic p;
    p = ~(^w) ^ bad;
    if (PAR) return {w, p};
    return {1'b0, w};
  endfunction

  // Bits [from, upto) of the frame, MSB first, with random gaps before each.
  task automatic send_bits(input logic [16:0] fv, input int from, input int upto, input int max_gap);
    int g;
    for (int i = from; i < upto; i++) begin
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int k = 0; k < g; k++) cycle(1'b1, 1'b0, 1'($urandom % 2), 1'b0);
      cycle(1'b1, 1'b1, fv[FB-1-i], 1'b0);
    end
  endtask

  logic [16:0] fv;

  initial begin
    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_word("rst_data", data_out, 16'h0000);
    check_bit("rst_cs", CS, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_err_frame", err_frame, 1'b0);
    check_bit("rst_err_parity", err_parity, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Good frame 0xA5C3 (parity bit 1 when enabled)
    fv = mkframe(16'hA5C3, 1'b0);
    $display("directed good frame word=a5c3");
    send_bits(fv, 0, FB, 0);
    check_bit("a5c3_n1_cs", CS, 1'b0);
    check_bit("a5c3_n1_busy", busy, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("a5c3_n2_cs", CS, 1'b1);
    check_word("a5c3_n2_data", data_out, 16'hA5C3);
    check_bit("a5c3_n2_err_parity", err_parity, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("a5c3_n3_cs", CS, 1'b0);
    idle(2);
    check_bit("a5c3_idle_busy", busy, 1'b0);

    // FRAME dropped after 9 bits, then a good 0x1234
    fv = mkframe(16'hFFFF, 1'b0);
    $display("directed short frame after 9 bits");
    send_bits(fv, 0, 9, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("short_err_frame", err_frame, 1'b1);
    check_bit("short_busy", busy, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("short_err_frame_clear", err_frame, 1'b0);
    fv = mkframe(16'h1234, 1'b0);
    $display("directed good frame word=1234");
    send_bits(fv, 0, FB, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("w1234_cs", CS, 1'b1);
    check_word("w1234_data", data_out, 16'h1234);
    idle(2);

`ifdef MKDS_DESER_PARITY_EN
    // 0xA5C3 with wrong parity: error, no CS, data_out keeps 0x1234
    fv = mkframe(16'hA5C3, 1'b1);
    $display("directed bad parity word=a5c3");
    send_bits(fv, 0, FB, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("badpar_err_parity", err_parity, 1'b1);
    check_bit("badpar_cs", CS, 1'b0);
    check_word("badpar_data", data_out, 16'h1234);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_bit("badpar_pulse_len", err_parity, 1'b0);
    idle(2);
`endif

    // Timeout: 8-cycle gap after 5 bits, later strobes ignored
    fv = mkframe(16'hBEEF, 1'b0);
    $display("directed timeout at bit 5");
    send_bits(fv, 0, 5, 0);
    for (int k = 0; k < TO - 1; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("to_early_err_frame", err_frame, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("to_err_frame", err_frame, 1'b1);
    check_bit("to_busy", busy, 1'b1);
    send_bits(fv, 5, FB, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("to_no_cs", CS, 1'b0);
    check_word("to_data_kept", data_out, 16'h1234);
    idle(2);
    check_bit("to_idle_busy", busy, 1'b0);

    // Reset at bit 10, then a clean frame
    fv = mkframe(16'hC0DE, 1'b0);
    $display("directed reset at bit 10");
    send_bits(fv, 0, 10, 0);
    cycle(1'b1, 1'b1, fv[FB-1-10], 1'b1);
    check_word("midrst_data", data_out, 16'h0000);
    check_bit("midrst_cs", CS, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_err_frame", err_frame, 1'b0);
    idle(1);
    fv = mkframe(16'h5A3C, 1'b0);
    send_bits(fv, 0, FB, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_bit("after_rst_cs", CS, 1'b1);
    check_word("after_rst_data", data_out, 16'h5A3C);
    idle(2);

    // Last bit coincides with FRAME falling
    fv = mkframe(16'h8001, 1'b0);
    $display("directed last bit with FRAME fall word=8001");
    send_bits(fv, 0, FB - 1, 0);
    cycle(1'b0, 1'b1, fv[0], 1'b0);
    check_bit("fall_n1_err_frame", err_frame, 1'b0);
    check_bit("fall_n1_busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("fall_n2_cs", CS, 1'b1);
    check_word("fall_n2_data", data_out, 16'h8001);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("fall_n3_busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("fall_n4_busy", busy, 1'b0);

    // Randomised frames checked against the model every cycle
    for (int t = 0; t < 120; t++) begin
      logic [15:0] w;
      int          kind;
      int          cut;
      bit          bad;
      w    = 16'($urandom);
      bad  = PAR && ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      cut  = $urandom_range(1, FB - 1);
      fv   = mkframe(w, bad);
      $display("frame %0d kind=%0d word=%04h bad_parity=%0d cut=%0d", t, kind, w, bad, cut);
      case (kind)
        0: begin
          send_bits(fv, 0, cut, 3);
          cycle(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
        end
        1: begin
          send_bits(fv, 0, cut, 3);
          for (int k = 0; k <= TO; k++) cycle(1'b1, 1'b0, 1'($urandom % 2), 1'b0);
          send_bits(fv, cut, FB, 2);
        end
        2: begin
          send_bits(fv, 0, cut, 3);
          cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
        end
        3: begin
          send_bits(fv, 0, FB - 1, 3);
          cycle(1'b0, 1'b1, fv[0], 1'b0);
        end
        default: begin
          send_bits(fv, 0, FB, 3);
        end
      endcase
      repeat ($urandom_range(0, 4)) cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
      idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mkds_cmd_deserializer.md
MKDS_CMD_DESERIALIZER -- requirements
Module: mkds_cmd_deserializer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max CLK cycles allowed between SVALID strobes inside a frame.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST, input, 1: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 SHALL have port SDI, input, 1: serial data bit, MSB first.
REQ-005 SHALL have port SVALID, input, 1: SDI is valid this cycle (one bit per strobe).
REQ-006 SHALL have port FRAME, input, 1: host frame gate, high for the duration of one command word.
REQ-007 SHALL have port data_out, output, 16: last accepted command word, feeding the downstream data_in bus.
REQ-008 SHALL have port CS, output, 1: one-cycle strobe marking data_out as a new valid word.
REQ-009 SHALL have port err_frame, output, 1: one-cycle pulse on a short or timed-out frame.
REQ-010 SHALL have port err_parity, output, 1: one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT, CHECK, EMIT and WAIT_END.
REQ-013 SHALL move IDLE->SHIFT on a cycle where FRAME=1, and SHALL accept an SVALID in that same cycle as bit 0.
REQ-014 SHALL, in SHIFT, shift SDI into the shift register on each SVALID and increment the bit counter; bits arriving without SVALID are ignored.
REQ-015 SHALL define frame length FB as 17 bits with MKDS_DESER_PARITY_EN and 16 bits without it.
REQ-016 SHALL go SHIFT->CHECK in the cycle after bit FB-1 is accepted (cycle N+1).
REQ-017 SHALL go CHECK->EMIT on a good frame; in EMIT (cycle N+2), data_out SHALL load the 16 data bits and CS SHALL be 1 for exactly one cycle.
REQ-018 SHALL go EMIT->WAIT_END, and WAIT_END->IDLE once FRAME=0; SVALID strobes in CHECK, EMIT and WAIT_END SHALL be ignored.
REQ-019 SHALL, if FRAME falls in SHIFT with fewer than FB bits accepted, pulse err_frame, discard the partial word and go to IDLE.
REQ-020 SHALL, when FRAME falls in the same cycle as an SVALID carrying bit FB-1, accept that bit and treat the frame as complete.
REQ-021 SHALL keep an idle counter in SHIFT, cleared on each SVALID; if it reaches TIMEOUT, SHALL pulse err_frame and go to WAIT_END.
REQ-022 SHALL hold data_out unchanged between EMIT cycles, and SHALL leave it unchanged on any error.
REQ-023 SHALL wrap the bit counter only through reset or a return to IDLE, never by overflow.

Reset
REQ-024 SHALL, on RST=1 at a CLK edge, set state=IDLE, data_out=16'h0000, CS=0, err_frame=0, err_parity=0, busy=0, and clear both counters and the shift register.
REQ-025 SHALL discard a partial word on reset mid-frame, with no CS and no error pulse.

Configuration
REQ-026 SHALL, with MKDS_DESER_PARITY_EN defined, treat bit 16 as odd parity over all 17 bits; on mismatch, CHECK SHALL pulse err_parity, suppress CS and go to WAIT_END.
REQ-027 SHALL, without MKDS_DESER_PARITY_EN, use a 16-bit frame and tie err_parity to 0.

Structure
REQ-028 SHALL place in package mkds_pkg the state enum, the FRAME_BITS_PAR=17 and FRAME_BITS_NOPAR=16 constants, and TIMEOUT_DEFAULT=255.
REQ-029 SHALL implement the idle/timeout counter as sub-module mkds_bit_timer (inputs clear and enable; output expired).

Verification
REQ-030 SHALL cover: parity build, frame 0xA5C3 + parity 1 -> data_out=16'hA5C3, CS high for exactly 1 cycle at N+2, no error.
REQ-031 SHALL cover: parity build, 0xA5C3 + parity 0 -> err_parity pulse, no CS, data_out keeps its previous value.
REQ-032 SHALL cover: FRAME dropped after 9 bits -> err_frame pulse, IDLE; a following good frame 0x1234 -> CS with data_out=16'h1234.
REQ-033 SHALL cover: TIMEOUT=8, SVALID gap of 8 cycles at bit 5 -> err_frame; extra SVALIDs ignored until FRAME=0.
REQ-034 SHALL cover: RST asserted at bit 10 -> all outputs at reset values next cycle, no CS; the next frame decodes correctly.
REQ-035 SHALL cover: the last bit's SVALID coincides with FRAME falling -> word accepted, CS at N+2.
